// File: rtl/nibble_serial_subtractor_16bit.sv
// Digit-serial subtractor: Diff = A - B - Bin, one DIGIT slice per clock, LSB first, with valid/ready on both sides.
// Optional macro SUB_SIGNED_OVF_EN adds a registered two's-complement overflow output Ovf.
`timescale 1ns/1ps
module nibble_serial_subtractor_16bit #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             Zero
`ifdef SUB_SIGNED_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic             borrow_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
   logic             zero_q;
   logic             in_ready_q;
   logic             out_valid_q;

   int               shamt;
   logic [DIGIT-1:0] aSlice;
   logic [DIGIT-1:0] bSlice;
   logic [DIGIT:0]   sliceRes;
   logic [WIDTH-1:0] diff_d;
   logic             lastStep;

   // Diff is cleared on accept, so each slice can simply be OR-ed into place.
   always_comb begin
      shamt    = DIGIT * int'(cnt_q);
      aSlice   = DIGIT'(a_q >> shamt);
      bSlice   = DIGIT'(b_q >> shamt);
      sliceRes = {1'b0, aSlice} - {1'b0, bSlice} - (DIGIT+1)'(borrow_q);
      diff_d   = diff_q | (WIDTH'(sliceRes[DIGIT-1:0]) << shamt);
      lastStep = (cnt_q == CW'(STEPS-1));
   end

`ifdef SUB_SIGNED_OVF_EN
   logic ovf_q;
   assign Ovf = ovf_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         borrow_q    <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         diff_q      <= '0;
         bout_q      <= 1'b0;
         zero_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= A;
                  b_q        <= B;
                  borrow_q   <= Bin;
                  diff_q     <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               diff_q   <= diff_d;
               borrow_q <= sliceRes[DIGIT];
               cnt_q    <= cnt_q + CW'(1);
               if (lastStep) begin
                  bout_q      <= sliceRes[DIGIT];
                  zero_q      <= (diff_d == '0);
`ifdef SUB_SIGNED_OVF_EN
                  ovf_q       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                 (diff_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign Diff      = diff_q;
   assign Bout      = bout_q;
   assign Zero      = zero_q;

endmodule
